// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the MIPS pipeline stages.
//   - Opcode and funct encodings, which the decode and memory stages also use.
//   - Execute-stage FSM state enum.
//   - Result bundle that the execute stage hands to the memory stage.
package mips_pkg;

  localparam int DATA_W = 32;

  // Primary opcodes (instruction bits [31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction bits [5:0]).
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } ex_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [4:0]        dest_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              zero;
  } ex_result_t;

endpackage

// File: rtl/booth_multiplier.sv
// booth_multiplier: radix-2 Booth signed multiplier, one step per clock.
//   clk, rst_n       : clock, async active-low reset
//   start_i          : load operands and begin (ignored when abort_i is high)
//   abort_i          : drop the in-flight multiply
//   multiplicand_i   : M operand (rs)
//   multiplier_i     : Q operand (rt)
//   done_o           : high during the cycle that executes the final step
//   product_o        : {A[W-1:0], Q}; valid from the cycle after done_o and
//                      held until the next start_i
module booth_multiplier #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  // A and M carry one extra sign bit so that M = -2^(W-1) negates exactly.
  logic [WIDTH:0]     a_q;
  logic [WIDTH:0]     m_q;
  logic [WIDTH-1:0]   q_q;
  logic               qm1_q;
  logic [CNT_W-1:0]   step_q;
  logic               busy_q;
  logic [WIDTH:0]     sum;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      m_q    <= '0;
      q_q    <= '0;
      qm1_q  <= 1'b0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else if (abort_i) begin
      step_q <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= '0;
      m_q    <= {multiplicand_i[WIDTH-1], multiplicand_i};
      q_q    <= multiplier_i;
      qm1_q  <= 1'b0;
      step_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      // Add/subtract, then arithmetic shift of {A, Q, q-1} right by one.
      a_q    <= {sum[WIDTH], sum[WIDTH:1]};
      q_q    <= {sum[0], q_q[WIDTH-1:1]};
      qm1_q  <= q_q[0];
      step_q <= step_q + 1'b1;
      if (step_q == LAST_STEP) busy_q <= 1'b0;
    end
  end

  assign done_o    = busy_q && (step_q == LAST_STEP);
  assign product_o = {a_q[WIDTH-1:0], q_q};

endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage MIPS pipeline.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : upstream handshake; in_ready is high only in IDLE
//   flush               : abort the in-flight instruction / block accept
//   opcode, read_data_1, read_data_2, sign_ext_imm, rt, rd : decoded operands
//   out_valid           : one-cycle strobe for the result bundle
//   alu_result, hi, store_data, dest_reg, reg_write, mem_read, mem_write,
//   zero                : result bundle; held while out_valid is low
// Single-cycle ops produce their result the cycle after accept. mult runs
// 32 Booth steps with in_ready low, then shows the product in DONE.
module execute_stage
  import mips_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] read_data_1,
  input  logic [WIDTH-1:0] read_data_2,
  input  logic [WIDTH-1:0] sign_ext_imm,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] store_data,
  output logic [4:0]       dest_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             zero
);

  ex_state_e        state_q, state_d;
  ex_result_t       alu_d, res_q, mul_res, out_bundle;
  logic [WIDTH-1:0] hi_q;
  logic             out_valid_q;
  logic [4:0]       mul_rd_q;
  logic [WIDTH-1:0] mul_sd_q;

  logic [5:0]         funct;
  logic               is_mult;
  logic               known;
  logic               accept;
  logic               show_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready && !flush;

  // Single-cycle ALU and control decode.
  always_comb begin
    funct   = sign_ext_imm[5:0];
    is_mult = (opcode == OP_RTYPE) && (funct == FN_MULT);
    known   = 1'b1;
    alu_d   = '0;
    alu_d.store_data = read_data_2;
    case (opcode)
      OP_RTYPE: begin
        alu_d.dest_reg  = rd;
        alu_d.reg_write = 1'b1;
        case (funct)
          FN_ADD:  alu_d.alu_result = read_data_1 + read_data_2;
          FN_SUB:  alu_d.alu_result = read_data_1 - read_data_2;
          FN_AND:  alu_d.alu_result = read_data_1 & read_data_2;
          FN_OR:   alu_d.alu_result = read_data_1 | read_data_2;
          FN_SLT:  alu_d.alu_result = {{(WIDTH-1){1'b0}},
                                       $signed(read_data_1) < $signed(read_data_2)};
          // mult takes the Booth path; this bundle is not used for it.
          default: known = 1'b0;
        endcase
      end
      OP_ADDI: begin
        alu_d.alu_result = read_data_1 + sign_ext_imm;
        alu_d.dest_reg   = rt;
        alu_d.reg_write  = 1'b1;
      end
      OP_LW: begin
        alu_d.alu_result = read_data_1 + sign_ext_imm;
        alu_d.dest_reg   = rt;
        alu_d.reg_write  = 1'b1;
        alu_d.mem_read   = 1'b1;
      end
      OP_SW: begin
        alu_d.alu_result = read_data_1 + sign_ext_imm;
        alu_d.dest_reg   = rt;
        alu_d.mem_write  = 1'b1;
      end
      OP_BEQ: begin
        alu_d.alu_result = read_data_1 - read_data_2;
        alu_d.dest_reg   = rt;
      end
      default: known = 1'b0;
    endcase
    if (known) begin
      alu_d.zero = (alu_d.alu_result == '0);
    end else begin
      // Unrecognised encoding retires as a NOP: no control flags asserted.
      alu_d = '0;
      alu_d.store_data = read_data_2;
    end
  end

  booth_multiplier #(
    .WIDTH (WIDTH),
    .STEPS (MUL_STEPS)
  ) u_booth (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (accept && is_mult),
    .abort_i        (flush && (state_q == MUL)),
    .multiplicand_i (read_data_1),
    .multiplier_i   (read_data_2),
    .done_o         (mul_done),
    .product_o      (product)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mult) state_d = MUL;
      MUL: begin
        if (flush)         state_d = IDLE;
        else if (mul_done) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_res            = '0;
    mul_res.alu_result = product[WIDTH-1:0];
    mul_res.store_data = mul_sd_q;
    mul_res.dest_reg   = mul_rd_q;
    mul_res.reg_write  = 1'b1;
  end

  // The product is presented straight from the Booth registers during DONE so
  // that a same-cycle flush can still cancel it; it is committed into the
  // output registers (and HI) only when DONE completes without a flush.
  assign show_mul   = (state_q == DONE) && !flush;
  assign out_bundle = show_mul ? mul_res : res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      res_q       <= '0;
      hi_q        <= '0;
      out_valid_q <= 1'b0;
      mul_rd_q    <= '0;
      mul_sd_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= accept && !is_mult;
      if (accept && !is_mult) res_q <= alu_d;
      if (accept && is_mult) begin
        mul_rd_q <= rd;
        mul_sd_q <= read_data_2;
      end
      if (show_mul) begin
        res_q <= mul_res;
        hi_q  <= product[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign out_valid  = out_valid_q || show_mul;
  assign hi         = show_mul ? product[2*WIDTH-1:WIDTH] : hi_q;
  assign alu_result = out_bundle.alu_result;
  assign store_data = out_bundle.store_data;
  assign dest_reg   = out_bundle.dest_reg;
  assign reg_write  = out_bundle.reg_write;
  assign mem_read   = out_bundle.mem_read;
  assign mem_write  = out_bundle.mem_write;
  assign zero       = out_bundle.zero;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: scoreboard bench for execute_stage. Expected bundles are
// built by a reference model when an instruction is accepted and compared,
// including arrival cycle, whenever the DUT asserts out_valid.
module tb_execute_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] read_data_1 = '0;
  logic [31:0] read_data_2 = '0;
  logic [31:0] sign_ext_imm = '0;
  logic [4:0]  rt = '0;
  logic [4:0]  rd = '0;
  logic        out_valid;
  logic [31:0] alu_result;
  logic [31:0] hi;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        zero;

  execute_stage #(.WIDTH(32), .MUL_STEPS(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .opcode       (opcode),
    .read_data_1  (read_data_1),
    .read_data_2  (read_data_2),
    .sign_ext_imm (sign_ext_imm),
    .rt           (rt),
    .rd           (rd),
    .out_valid    (out_valid),
    .alu_result   (alu_result),
    .hi           (hi),
    .store_data   (store_data),
    .dest_reg     (dest_reg),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        z;
    logic        chk_data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] hi_model = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input string name, input logic [5:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [4:0] t,
                                 input logic [4:0] d);
    exp_t e;
    logic signed [63:0] sa, sb, p;
    e.name = name; e.res = '0; e.hi = hi_model; e.sd = b; e.dest = '0;
    e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.z = 1'b0; e.chk_data = 1'b1; e.cyc = 0;
    if (op == OP_RTYPE) begin
      e.dest = d;
      e.rw   = 1'b1;
      case (imm[5:0])
        FN_ADD:  e.res = a + b;
        FN_SUB:  e.res = a - b;
        FN_AND:  e.res = a & b;
        FN_OR:   e.res = a | b;
        FN_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        FN_MULT: begin
          sa = $signed(a);
          sb = $signed(b);
          p  = sa * sb;
          e.res = p[31:0];
          e.hi  = p[63:32];
        end
        default: begin
          e.rw = 1'b0;
          e.chk_data = 1'b0;
        end
      endcase
      e.z = (e.rw && imm[5:0] != FN_MULT) ? (e.res == 32'd0) : 1'b0;
    end else begin
      case (op)
        OP_ADDI: begin e.res = a + imm; e.dest = t; e.rw = 1'b1; end
        OP_LW:   begin e.res = a + imm; e.dest = t; e.rw = 1'b1; e.mr = 1'b1; end
        OP_SW:   begin e.res = a + imm; e.dest = t; e.mw = 1'b1; end
        OP_BEQ:  begin e.res = a - b;   e.dest = t; end
        default: e.chk_data = 1'b0;
      endcase
      if (e.chk_data) e.z = (op == OP_BEQ) ? (a == b) : (e.res == 32'd0);
    end
    return e;
  endfunction

  // Scoreboard consumer: every out_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "/cycle"}, cyc, e.cyc);
        check({e.name, "/hi"}, hi, e.hi);
        check({e.name, "/flags"}, {reg_write, mem_read, mem_write, zero},
              {e.rw, e.mr, e.mw, e.z});
        if (e.chk_data) begin
          check({e.name, "/alu_result"}, alu_result, e.res);
          check({e.name, "/store_data"}, store_data, e.sd);
          check({e.name, "/dest_reg"}, dest_reg, e.dest);
        end
      end
    end
  end

  task automatic issue(input string name, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] t,
                       input logic [4:0] d, input bit expect_out, output int acc);
    exp_t e;
    int waited;
    opcode = op; read_data_1 = a; read_data_2 = b; sign_ext_imm = imm;
    rt = t; rd = d; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check({name, "/accept"}, in_ready, 1);
    acc = cyc;
    if (expect_out) begin
      e = model(name, op, a, b, imm, t, d);
      if (op == OP_RTYPE && imm[5:0] == FN_MULT) begin
        e.cyc = acc + 33;
        hi_model = e.hi;
      end else begin
        e.cyc = acc + 1;
      end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, stall, vk;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset/in_ready", in_ready, 1);
    check("reset/out_valid", out_valid, 0);
    check("reset/alu_result", alu_result, 0);
    check("reset/hi", hi, 0);
    check("reset/bundle", {store_data, dest_reg, reg_write, mem_read, mem_write, zero}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back single-cycle ops.
    issue("add",      OP_RTYPE, 32'd5, 32'd7, 32'(FN_ADD), 5'd7, 5'd3, 1, acc);
    issue("sub",      OP_RTYPE, 32'd5, 32'd7, 32'(FN_SUB), 5'd7, 5'd4, 1, acc);
    issue("sub_zero", OP_RTYPE, 32'd9, 32'd9, 32'(FN_SUB), 5'd1, 5'd5, 1, acc);
    issue("and",      OP_RTYPE, 32'hF0F0_1234, 32'h0FF0_FF00, 32'(FN_AND), 5'd2, 5'd6, 1, acc);
    issue("or",       OP_RTYPE, 32'hF000_0001, 32'h0000_8000, 32'(FN_OR), 5'd2, 5'd7, 1, acc);
    issue("slt_true", OP_RTYPE, 32'hFFFF_FFFD, 32'd7, 32'(FN_SLT), 5'd2, 5'd8, 1, acc);
    issue("slt_false",OP_RTYPE, 32'd7, 32'hFFFF_FFFD, 32'(FN_SLT), 5'd2, 5'd9, 1, acc);
    issue("addi",     OP_ADDI, 32'h10, 32'hAAAA, 32'hFFFF_FFFF, 5'd11, 5'd31, 1, acc);
    issue("lw",       OP_LW,   32'h100, 32'h55, 32'hFFFF_FFFC, 5'd9, 5'd30, 1, acc);
    issue("sw",       OP_SW,   32'h200, 32'hDEAD_BEEF, 32'd8, 5'd12, 5'd29, 1, acc);
    issue("beq_eq",   OP_BEQ,  32'h1234, 32'h1234, 32'd16, 5'd13, 5'd0, 1, acc);
    issue("beq_ne",   OP_BEQ,  32'h1234, 32'h1235, 32'd16, 5'd14, 5'd0, 1, acc);
    issue("bad_op",   6'h3F,   32'd1, 32'd2, 32'd3, 5'd15, 5'd16, 1, acc);
    issue("bad_funct",OP_RTYPE, 32'd1, 32'd2, 32'h3F, 5'd15, 5'd16, 1, acc);
    repeat (2) @(posedge clk);
    #1;

    // mult -3 * 7 with stall and latency measurement.
    issue("mult_neg", OP_RTYPE, 32'hFFFF_FFFD, 32'd7, 32'(FN_MULT), 5'd1, 5'd4, 1, acc);
    stall = 0;
    vk = 0;
    for (int k = 1; k <= 34; k++) begin
      if (!in_ready) stall++;
      if (out_valid && vk == 0) vk = k;
      if (k < 34) begin
        @(posedge clk); #1;
      end
    end
    check("mult_neg/stall_cycles", stall, 33);
    check("mult_neg/valid_cycle", vk, 33);

    // Boundary products.
    issue("mult_minmin", OP_RTYPE, 32'h8000_0000, 32'h8000_0000, 32'(FN_MULT), 5'd2, 5'd5, 1, acc);
    issue("mult_maxmin", OP_RTYPE, 32'h7FFF_FFFF, 32'h8000_0000, 32'(FN_MULT), 5'd2, 5'd6, 1, acc);

    // add held on in_valid during a mult.
    issue("mult_hold", OP_RTYPE, 32'h0001_2345, 32'hFFFF_0F00, 32'(FN_MULT), 5'd3, 5'd7, 1, acc);
    issue("add_held",  OP_RTYPE, 32'h40, 32'h2, 32'(FN_ADD), 5'd3, 5'd8, 1, acc2);
    check("add_held/accept_gap", acc2 - acc, 34);
    repeat (3) @(posedge clk);
    #1;

    // flush at step 10 of a mult.
    issue("mult_flush", OP_RTYPE, 32'h11, 32'h22, 32'(FN_MULT), 5'd3, 5'd9, 0, acc);
    repeat (10) @(posedge clk);
    #1;
    check("mult_flush/busy", in_ready, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("mult_flush/in_ready", in_ready, 1);
    repeat (40) @(posedge clk);
    #1;
    check("mult_flush/hi_kept", hi, hi_model);

    // flush coinciding with DONE.
    issue("mult_fdone", OP_RTYPE, 32'h33, 32'h44, 32'(FN_MULT), 5'd3, 5'd10, 0, acc);
    repeat (32) @(posedge clk);
    #1;
    check("mult_fdone/in_done", out_valid, 1);
    flush = 1'b1;
    #1;
    check("mult_fdone/valid_suppressed", out_valid, 0);
    check("mult_fdone/hi_kept", hi, hi_model);
    @(posedge clk); #1;
    flush = 1'b0;
    check("mult_fdone/in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("mult_fdone/hi_after", hi, hi_model);

    // flush in IDLE blocks the accept.
    opcode = OP_RTYPE; read_data_1 = 32'd1; read_data_2 = 32'd1;
    sign_ext_imm = 32'(FN_ADD); rt = 5'd1; rd = 5'd2;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle/no_output", out_valid, 0);
    issue("add_after_flush", OP_RTYPE, 32'd100, 32'd23, 32'(FN_ADD), 5'd1, 5'd2, 1, acc);
    repeat (2) @(posedge clk);
    #1;

    // Reset at step 10 of a mult.
    issue("mult_reset", OP_RTYPE, 32'h55, 32'h66, 32'(FN_MULT), 5'd3, 5'd11, 0, acc);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mult_reset/out_valid", out_valid, 0);
    check("mult_reset/hi", hi, 0);
    check("mult_reset/alu_result", alu_result, 0);
    check("mult_reset/in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hi_model = '0;
    repeat (40) @(posedge clk);
    #1;
    check("mult_reset/hi_after", hi, 0);
    check("mult_reset/in_ready_after", in_ready, 1);
    issue("add_after_reset", OP_RTYPE, 32'hFFFF_FFFF, 32'd1, 32'(FN_ADD), 5'd4, 5'd12, 1, acc);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage pipelined MIPS core, directly downstream of instruction decode. It consumes the decoded opcode, register-file read data, sign-extended immediate and rt/rd fields, and performs the ALU operation or effective-address computation. It produces a registered result bundle for the memory stage. Signed `mult` runs on a 32-step radix-2 Booth engine that stalls the upstream stage through a valid/ready handshake.

## Interface
Parameters
- `WIDTH`, 32: datapath width; only 32 is supported.
- `MUL_STEPS`, 32: Booth iterations; must equal `WIDTH`.

Ports
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: decoded instruction present.
- `in_ready`  out  1: stage can accept; equals (state == IDLE).
- `flush`  in  1: synchronous abort of the in-flight instruction.
- `opcode`  in  6: instruction [31:26].
- `read_data_1`  in  32: rs value.
- `read_data_2`  in  32: rt value.
- `sign_ext_imm`  in  32: immediate; bits [5:0] are `funct` for R-type.
- `rt`, `rd`  in  5 each: register specifiers.
- `out_valid`  out  1: result bundle valid for exactly one cycle.
- `alu_result`  out  32: ALU result, address, or LO of product.
- `hi`  out  32: HI register; updated only by `mult`.
- `store_data`  out  32: `read_data_2` captured at accept.
- `dest_reg`  out  5: rd for R-type, rt for I-type.
- `reg_write`, `mem_read`, `mem_write`, `zero`  out  1 each: control flags.

## Operation
- Accept occurs when `in_valid && in_ready`. All operands are captured at accept.
- R-type (opcode 0x00), selected by funct:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or: wrap-around arithmetic, no overflow trap.
  - 0x2A slt: signed compare, result 1 or 0.
  - 0x18 mult: Booth multiply.
  - All R-type: `reg_write`=1, `dest_reg`=rd.
- I-type:
  - 0x08 addi: `reg_write`=1.
  - 0x23 lw: address = rs+imm; `mem_read`=1, `reg_write`=1.
  - 0x2B sw: address = rs+imm; `mem_write`=1, `store_data`=rt.
  - 0x04 beq: `zero` = (rs == rt); `alu_result` = rs−rt; no write.
- Unknown opcode or funct: `out_valid`=1 with all control flags 0 (acts as a NOP).
- `zero` = (`alu_result` == 0) for all ops except `mult`, where `zero`=0.
- FSM states:
  - IDLE: a non-mult accept stays in IDLE. A mult accept moves to MUL.
  - MUL: one Booth step per cycle; `step` counter runs 0..31. After step 31 the FSM moves to DONE.
  - DONE: `out_valid`=1, `alu_result`=LO, `hi`=HI; next cycle returns to IDLE.
- Booth datapath:
  - Registers: 33-bit signed accumulator A (init 0), Q = multiplier (rt), q₋₁ = 0, M = sign-extended multiplicand (rs, 33 bits).
  - Per step: on {Q[0],q₋₁} = 01, A += M; on 10, A −= M. Then arithmetic-shift {A,Q,q₋₁} right by 1.
  - Product = {A[31:0], Q}. The 33-bit A makes M = −2³¹ exact.
- `flush`:
  - In IDLE, `flush` blocks accept that cycle.
  - In MUL or DONE, `flush` returns the FSM to IDLE and suppresses `out_valid`; `hi` is not updated.
- No output backpressure: the memory stage always consumes `out_valid`.

## Timing
- Reset value of every output is 0, including `hi`, except `in_ready`=1. State resets to IDLE.
- Non-mult: accept at cycle N gives `out_valid` at N+1. Back-to-back accepts sustain 1 instruction per cycle.
- Mult: accept at N; steps execute in cycles N+1..N+32; `out_valid` at N+33. `in_ready`=0 for cycles N+1..N+33, and the next accept can occur at N+34.
- `rst_n` low during MUL aborts immediately: outputs go to 0, no `out_valid` is emitted, and `hi` is cleared.
- `flush` and DONE in the same cycle: flush wins and `out_valid`=0.
- Outputs other than `out_valid` hold their last values when `out_valid`=0.

## Structure
- Shared package `mips_pkg`: opcode constants, funct constants, and the FSM state enum (IDLE/MUL/DONE). The decode and memory stages reuse the opcode and funct constants.
- Sub-module `booth_multiplier`: has `start`, `done`, a 5-bit step counter, and the A/Q/q₋₁ registers. `execute_stage` owns the FSM, ALU, control decode, and output registers.

## Test plan
- add rs=5, rt=7, rd=3 → cycle N+1: `alu_result`=12, `dest_reg`=3, `reg_write`=1, `zero`=0.
- mult rs=−3, rt=7 → `in_ready`=0 for 33 cycles; at N+33: `alu_result`=0xFFFFFFEB, `hi`=0xFFFFFFFF.
- mult rs=rt=0x80000000 → `hi`=0x40000000, `alu_result`=0. Repeat with 0x7FFFFFFF × 0x80000000 → `hi`=0xC0000000, `alu_result`=0x80000000.
- Hold `in_valid`=1 with an add during a mult → the add is not accepted until N+34, then completes at N+35.
- Drive `rst_n` low at step 10 of a mult, then release → no `out_valid`, `hi`=0, `in_ready`=1. Also: `flush` at step 10 → IDLE with no output, and `hi` retains its old value.
- beq rs=rt=0x1234 → `zero`=1, `reg_write`=0. lw rs=0x100, imm=−4 → `alu_result`=0xFC, `mem_read`=1, `dest_reg`=rt.
